// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-4 demux: channel state encoding and counter sizing.
package demux_pkg;

    typedef enum logic {
        CH_EMPTY = 1'b0,
        CH_FULL  = 1'b1
    } chan_state_e;

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

endpackage

// File: rtl/demux_chan_reg.sv
// One output channel of the demux: an n-bit holding register with EMPTY/FULL state.
module demux_chan_reg
    import demux_pkg::*;
#(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [n-1:0] data,
    input  logic         ready,
    output logic [n-1:0] Y,
    output logic         V
);

    chan_state_e  r_state;
    chan_state_e  w_state_nxt;
    logic [n-1:0] r_data;

    // A load wins over a drain so a same-cycle refill keeps the channel FULL.
    always_comb begin
        w_state_nxt = r_state;
        if (load)
            w_state_nxt = CH_FULL;
        else if ((r_state == CH_FULL) && ready)
            w_state_nxt = CH_EMPTY;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= CH_EMPTY;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (load)
                r_data <= data;
        end
    end

    assign V = (r_state == CH_FULL);
    assign Y = r_data;

endmodule

// File: rtl/demux_1x4_nbit.sv
// 1-to-4 valid/ready demultiplexer with a one-word buffer per channel.
// Optional per-channel transfer counters C0..C3 enabled by DEMUX_1X4_NBIT_CNT_EN.
module demux_1x4_nbit
    import demux_pkg::*;
#(
    parameter int n = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [n-1:0]     A,
    input  logic [1:0]       S,
    input  logic             in_valid,
    output logic             in_ready,
`ifdef DEMUX_1X4_NBIT_CNT_EN
    output logic [CNT_W-1:0] C0,
    output logic [CNT_W-1:0] C1,
    output logic [CNT_W-1:0] C2,
    output logic [CNT_W-1:0] C3,
`endif
    output logic [n-1:0]     Y0,
    output logic [n-1:0]     Y1,
    output logic [n-1:0]     Y2,
    output logic [n-1:0]     Y3,
    output logic             V0,
    output logic             V1,
    output logic             V2,
    output logic             V3,
    input  logic             R0,
    input  logic             R1,
    input  logic             R2,
    input  logic             R3
);

    logic [3:0][n-1:0] w_y;
    logic [3:0]        w_v;
    logic [3:0]        w_r;
    logic [3:0]        w_load;
    logic [3:0]        w_xfer;

    assign w_r = {R3, R2, R1, R0};

    // Depends only on S, channel state and the consumer ready, never on in_valid.
    assign in_ready = ~w_v[S] | w_r[S];

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_chan
            assign w_load[g] = in_valid & in_ready & (S == 2'(g));
            assign w_xfer[g] = w_v[g] & w_r[g];

            demux_chan_reg #(.n(n)) u_chan (
                .clk   (clk),
                .rst_n (rst_n),
                .load  (w_load[g]),
                .data  (A),
                .ready (w_r[g]),
                .Y     (w_y[g]),
                .V     (w_v[g])
            );
        end
    endgenerate

    assign {Y3, Y2, Y1, Y0} = {w_y[3], w_y[2], w_y[1], w_y[0]};
    assign {V3, V2, V1, V0} = w_v;

`ifdef DEMUX_1X4_NBIT_CNT_EN
    logic [3:0][CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            for (int k = 0; k < 4; k++)
                if (w_xfer[k] && (r_cnt[k] != CNT_MAX))
                    r_cnt[k] <= r_cnt[k] + 1'b1;
        end
    end

    assign {C3, C2, C1, C0} = {r_cnt[3], r_cnt[2], r_cnt[1], r_cnt[0]};
`else
    logic w_unused_xfer;
    assign w_unused_xfer = ^w_xfer;
`endif

endmodule

// File: tb/tb_demux_1x4_nbit.sv
// Directed self-checking bench for demux_1x4_nbit (n=4); counter checks need DEMUX_1X4_NBIT_CNT_EN.
module tb_demux_1x4_nbit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] A;
    logic [1:0] S;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] Y0, Y1, Y2, Y3;
    logic       V0, V1, V2, V3;
    logic       R0, R1, R2, R3;
`ifdef DEMUX_1X4_NBIT_CNT_EN
    logic [7:0] C0, C1, C2, C3;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    demux_1x4_nbit #(.n(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .A        (A),
        .S        (S),
        .in_valid (in_valid),
        .in_ready (in_ready),
`ifdef DEMUX_1X4_NBIT_CNT_EN
        .C0       (C0),
        .C1       (C1),
        .C2       (C2),
        .C3       (C3),
`endif
        .Y0       (Y0),
        .Y1       (Y1),
        .Y2       (Y2),
        .Y3       (Y3),
        .V0       (V0),
        .V1       (V1),
        .V2       (V2),
        .V3       (V3),
        .R0       (R0),
        .R1       (R1),
        .R2       (R2),
        .R3       (R3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] s, input logic [3:0] a);
        in_valid = 1'b1; S = s; A = a;
    endtask

    logic [3:0] vec_a [4];

    initial begin
        vec_a[0] = 4'hA; vec_a[1] = 4'h5; vec_a[2] = 4'hF; vec_a[3] = 4'h0;
        rst_n = 1'b0; A = '0; S = '0; in_valid = 1'b0;
        {R3, R2, R1, R0} = 4'b1111;

        // reset held two edges
        step(); step();
        chk("rst_v", {V3, V2, V1, V0}, 4'b0000);
        chk("rst_y", {Y3, Y2, Y1, Y0}, 16'h0000);
        for (int s = 0; s < 4; s++) begin
            S = 2'(s); #1;
            chk($sformatf("rst_rdy_s%0d", s), in_ready, 1'b1);
        end
        rst_n = 1'b1;

        // one word per channel on consecutive cycles, all consumers ready
        for (int k = 0; k < 4; k++) begin
            send(2'(k), vec_a[k]);
            step();
            case (k)
                0: begin chk("seq_v_0", {V3, V2, V1, V0}, 4'b0001); chk("seq_y0", Y0, 4'hA); end
                1: begin chk("seq_v_1", {V3, V2, V1, V0}, 4'b0010); chk("seq_y1", Y1, 4'h5); end
                2: begin chk("seq_v_2", {V3, V2, V1, V0}, 4'b0100); chk("seq_y2", Y2, 4'hF); end
                default: begin chk("seq_v_3", {V3, V2, V1, V0}, 4'b1000); chk("seq_y3", Y3, 4'h0); end
            endcase
        end
        in_valid = 1'b0;
        step();
        chk("seq_drain", {V3, V2, V1, V0}, 4'b0000);

        // in_valid low: A and S ignored
        A = 4'h9; S = 2'd2;
        step();
        chk("idle_v", {V3, V2, V1, V0}, 4'b0000);

        // backpressure on channel 2
        R2 = 1'b0;
        send(2'd2, 4'hC);
        step();
        in_valid = 1'b0;
        chk("bp_v2", V2, 1'b1);
        chk("bp_y2", Y2, 4'hC);
        step(); step();
        chk("bp_hold_y2", Y2, 4'hC);
        chk("bp_hold_v2", V2, 1'b1);
        send(2'd2, 4'h7); #1;
        chk("bp_rdy_lo", in_ready, 1'b0);
        S = 2'd0; #1;
        chk("bp_rdy_other", in_ready, 1'b1);
        S = 2'd2;
        step();
        chk("bp_still_y2", Y2, 4'hC);
        R2 = 1'b1; #1;
        chk("bp_rdy_hi", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        chk("bp_new_v2", V2, 1'b1);
        chk("bp_new_y2", Y2, 4'h7);
        step();
        chk("bp_empty_v2", V2, 1'b0);

        // channel 1 refilled in the same cycle it drains
        R1 = 1'b0;
        send(2'd1, 4'h9);
        step();
        send(2'd1, 4'h3);
        R1 = 1'b1;
        step();
        in_valid = 1'b0;
        chk("tp_v1", V1, 1'b1);
        chk("tp_y1", Y1, 4'h3);
        step();
        chk("tp_v1_drain", V1, 1'b0);

        // fill all four, then drain all in one cycle
        {R3, R2, R1, R0} = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            send(2'(k), 4'(k + 4'h4));
            step();
        end
        in_valid = 1'b0;
        chk("all_full_v", {V3, V2, V1, V0}, 4'b1111);
        chk("all_full_y", {Y3, Y2, Y1, Y0}, 16'h7654);
        {R3, R2, R1, R0} = 4'b1111;
        step();
        chk("all_drain_v", {V3, V2, V1, V0}, 4'b0000);

        // mid-operation reset discards buffered words
        {R3, R0} = 2'b00;
        send(2'd0, 4'h1); step();
        send(2'd3, 4'h2); step();
        in_valid = 1'b0;
        chk("mr_pre_v", {V3, V0}, 2'b11);
        rst_n = 1'b0;
        {R3, R0} = 2'b11;
        step();
        rst_n = 1'b1;
        chk("mr_v", {V3, V2, V1, V0}, 4'b0000);
        chk("mr_y", {Y3, Y0}, 8'h00);

`ifdef DEMUX_1X4_NBIT_CNT_EN
        rst_n = 1'b0; step(); rst_n = 1'b1;
        chk("cnt_rst", {C3, C2, C1, C0}, 32'h0);
        send(2'd0, 4'h5);
        for (int i = 0; i < 300; i++) step();
        in_valid = 1'b0;
        step(); step();
        chk("cnt_c0_sat", C0, 8'd255);
        chk("cnt_others", {C3, C2, C1}, 24'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux_1x4_nbit.md
DEMUX_1X4_NBIT -- requirements
Module: demux_1x4_nbit

Interface
REQ-001 SHALL have parameter n, default 4, data width in bits (n >= 1).
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-004 SHALL have port A, input, n, input data word.
REQ-005 SHALL have port S, input, 2, destination select (00->ch0, 01->ch1, 10->ch2, 11->ch3).
REQ-006 SHALL have port in_valid, input, 1, A/S valid this cycle.
REQ-007 SHALL have port in_ready, output, 1, block accepts A this cycle.
REQ-008 SHALL have ports Y0..Y3, output, n each, channel data.
REQ-009 SHALL have ports V0..V3, output, 1 each, channel data valid.
REQ-010 SHALL have ports R0..R3, input, 1 each, channel consumer ready.

Function
REQ-011 SHALL hold one n-bit register plus a 1-bit state per channel: EMPTY or FULL.
REQ-012 SHALL drive Vk = 1 exactly when channel k is FULL, and Yk = channel k register contents.
REQ-013 SHALL treat an input transfer as in_valid & in_ready, and a channel-k transfer as Vk & Rk.
REQ-014 SHALL drive in_ready = (channel S is EMPTY) | Rk of channel S; combinational from S, channel state and Rk only, never from in_valid.
REQ-015 SHALL, on an input transfer, load A into channel S and set it FULL on the next edge; latency from input to Vk is 1 cycle.
REQ-016 SHALL, on a channel-k transfer without a simultaneous input transfer to k, set channel k EMPTY.
REQ-017 SHALL, on simultaneous channel-k transfer and input transfer to k, load the new word and keep k FULL (full throughput, 1 word/cycle per channel).
REQ-018 SHALL leave channels not addressed by S unchanged except for their own drain.
REQ-019 SHALL hold Yk stable while Vk=1 and Rk=0.
REQ-020 SHALL ignore A and S when in_valid=0; no state change on the input side.
REQ-021 SHALL allow all four channels to drain in the same cycle independently.

Reset
REQ-022 SHALL, while rst_n=0 at a rising edge, set all channels EMPTY, Y0..Y3 = 0, V0..V3 = 0.
REQ-023 SHALL discard buffered words on a mid-operation reset; no transfer completes on that edge.
REQ-024 SHALL assert in_ready after reset for any S (all channels EMPTY).

Configuration
REQ-025 SHALL, with macro DEMUX_1X4_NBIT_CNT_EN defined, add outputs C0..C3, 8 bits each: count of channel-k transfers, saturating at 255, cleared by reset.
REQ-026 SHALL, without DEMUX_1X4_NBIT_CNT_EN, omit C0..C3 and all counter logic; all other behaviour identical.

Structure
REQ-027 SHALL place the channel-state encoding (EMPTY=0, FULL=1) and the counter width constant (8) in shared package demux_pkg.
REQ-028 SHALL implement each channel as sub-module demux_chan_reg (parameter n; ports clk, rst_n, load, data, ready, Y, V), instantiated four times.

Verification
REQ-029 SHALL cover: reset with rst_n=0 for 2 cycles -> V0..V3=0, Y0..Y3=0, in_ready=1.
REQ-030 SHALL cover: n=4, R0..R3=1, send A=4'hA S=00, 4'h5 S=01, 4'hF S=10, 4'h0 S=11 on consecutive cycles -> each Vk pulses one cycle after its send with Yk as sent.
REQ-031 SHALL cover: R2=0, send 4'hC S=10 -> V2=1, Y2=4'hC held; second send to S=10 sees in_ready=0 until R2=1, then Y2 updates the cycle after.
REQ-032 SHALL cover: channel 1 FULL with R1=1 and in_valid=1 S=01 A=4'h3 same cycle -> V1 stays 1, Y1=4'h3 next cycle, no bubble.
REQ-033 SHALL cover: channels 0 and 3 FULL, rst_n=0 for one edge -> both EMPTY, outputs 0 next cycle.
REQ-034 SHALL cover (with DEMUX_1X4_NBIT_CNT_EN): 300 back-to-back transfers on channel 0 -> C0=255, C1..C3=0.
